// File: rtl/math_core_alu.sv
// math_core_alu: two-stage valid/ready math engine (add/sub/mul/max) with a
// saturating, reloadable completion counter for state migration across swaps.
// Bit 0 of every vector port is the MSB.
module math_core_alu #(
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:1]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:DW-1] ain,
    input  logic [0:DW-1] bin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:DW-1] result,
    output logic          ovf,
    output logic [0:CW-1] statistic,
    input  logic          stat_ld,
    input  logic [0:CW-1] stat_din,
    input  logic          flush,
    output logic          busy
);

    // Operation datapath: returns {ovf, result}, all arithmetic unsigned mod 2^DW.
    function automatic logic [DW:0] alu_op(input logic [1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW:0]     ext;
        logic [2*DW-1:0] prod;
        ext    = '0;
        prod   = '0;
        alu_op = '0;
        case (op)
            2'b00: alu_op = {1'b0, a} + {1'b0, b};
            2'b01: begin
                // Bit DW of the extended difference is the borrow (a < b).
                ext    = {1'b0, a} - {1'b0, b};
                alu_op = {ext[DW], ext[DW-1:0]};
            end
            2'b10: begin
                prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                alu_op = {|prod[2*DW-1:DW], prod[DW-1:0]};
            end
            default: alu_op = {1'b0, (a > b) ? a : b};
        endcase
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    logic [0:DW-1] r_a_p1;
    logic [0:DW-1] r_b_p1;
    logic [1:0]    r_mode_p1;
    logic          r_vld_p1;
    logic [0:DW-1] r_res_p2;
    logic          r_ovf_p2;
    logic          r_vld_p2;
    logic [0:CW-1] r_stat;

    logic          w_take_p2;
    logic          w_acc;
    logic          w_adv;
    logic          w_hs;
    logic [DW:0]   w_alu_p1;

    // Flush blocks new accepts and suppresses the handshake/transfer of its cycle.
    assign w_take_p2 = !r_vld_p2 || out_ready;
    assign in_ready  = !flush && (!r_vld_p1 || w_take_p2);
    assign w_acc     = in_valid && in_ready;
    assign w_adv     = r_vld_p1 && w_take_p2 && !flush;
    assign w_hs      = r_vld_p2 && out_ready && !flush;
    assign w_alu_p1  = alu_op(r_mode_p1, r_a_p1, r_b_p1);

    assign out_valid = r_vld_p2;
    assign result    = r_res_p2;
    assign ovf       = r_ovf_p2;
    assign statistic = r_stat;
    assign busy      = r_vld_p1 || r_vld_p2;

    // Stage-occupancy flags and completion counter (load beats a same-cycle completion).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_stat   <= '0;
        end else begin
            if (flush)      r_vld_p1 <= 1'b0;
            else if (w_acc) r_vld_p1 <= 1'b1;
            else if (w_adv) r_vld_p1 <= 1'b0;

            if (flush)      r_vld_p2 <= 1'b0;
            else if (w_adv) r_vld_p2 <= 1'b1;
            else if (w_hs)  r_vld_p2 <= 1'b0;

            if (stat_ld)    r_stat <= stat_din;
            else if (w_hs)  r_stat <= sat_inc(r_stat);
        end
    end

    // ---- stage 1: operand capture on accept ----
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_a_p1    <= ain;
            r_b_p1    <= bin;
            r_mode_p1 <= mode;
        end
    end

    // ---- stage 2: result register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_p2 <= '0;
            r_ovf_p2 <= 1'b0;
        end else if (w_adv) begin
            r_res_p2 <= w_alu_p1[DW-1:0];
            r_ovf_p2 <= w_alu_p1[DW];
        end
    end

endmodule

// File: tb/tb_math_core_alu.sv
// Testbench for math_core_alu: directed scenarios plus random traffic, checked
// by a scoreboard fed from a plain-arithmetic reference model.
module tb_math_core_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ain = '0;
    logic [31:0] bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic [31:0] statistic;
    logic        stat_ld = 1'b0;
    logic [31:0] stat_din = '0;
    logic        flush = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [32:0]      sb_q[$];
    longint unsigned  stat_m = 0;
    logic             prev_stall = 1'b0;
    logic [32:0]      prev_out = '0;

    math_core_alu #(.DW(32), .CW(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .ain(ain), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .statistic(statistic), .stat_ld(stat_ld),
        .stat_din(stat_din), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf, result} from the arithmetic definitions.
    function automatic logic [32:0] ref_op(input logic [1:0] m, input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned la, lb, r;
        la = a;
        lb = b;
        case (m)
            2'b00: begin r = la + lb; return {r > 64'hFFFF_FFFF, r[31:0]}; end
            2'b01: begin r = la - lb; return {la < lb, r[31:0]}; end
            2'b10: begin r = la * lb; return {r > 64'hFFFF_FFFF, r[31:0]}; end
            default: return {1'b0, (la > lb) ? a : b};
        endcase
    endfunction

    // Monitor/scoreboard: sample between edges, model what the next edge does.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_statistic", statistic, 0);
            check("rst_result", {ovf, result}, 0);
            sb_q.delete();
            stat_m = 0;
            prev_stall = 1'b0;
        end else begin
            check("statistic", statistic, stat_m);
            check("busy", busy, sb_q.size() != 0);
            check("in_ready", in_ready, !flush && (sb_q.size() < 2 || out_ready));
            if (prev_stall && !flush && out_valid)
                check("hold_stable", {ovf, result}, prev_out);
            if (out_valid && sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out: out_valid=1 with nothing in flight at %0t", $time);
            end
            if (out_valid && out_ready && !flush && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result", result, e[31:0]);
                check("ovf", ovf, e[32]);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_out   = {ovf, result};
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(ref_op(mode, ain, bin));
            if (stat_ld) stat_m = stat_din;
            else if (out_valid && out_ready && !flush && stat_m != 64'hFFFF_FFFF) stat_m++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and hold it until the accepting edge has passed.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        logic acc;
        acc = 1'b0;
        ain = a; bin = b; mode = m; in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: pair never accepted at %0t", $time);
        end
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        for (t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
        step();
    endtask

    initial begin
        logic [31:0] base;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        step();
        check("ready_after_rst", in_ready, 1);

        // Add with carry-out and pipeline latency.
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'h2, 2'b00);
        check("lat_not_yet", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("lat_result", result, 32'h1);
        step();
        check("stat_one", statistic, 1);

        // Operation sweep, back-to-back.
        send(32'd5, 32'd7, 2'b01);
        send(32'd5, 32'd7, 2'b11);
        send(32'h10000, 32'h10000, 2'b10);
        send(32'd3, 32'd4, 2'b10);
        drain();

        // Backpressure: only two pairs fit while the consumer stalls.
        base = statistic;
        out_ready = 1'b0;
        send(32'd10, 32'd20, 2'b00);
        send(32'd30, 32'd40, 2'b01);
        ain = 32'd50; bin = 32'd60; mode = 2'b11; in_valid = 1'b1;
        repeat (3) step();
        check("bp_ready_low", in_ready, 0);
        check("bp_inflight", sb_q.size(), 2);
        out_ready = 1'b1;
        #1 check("bp_ready_same_cycle", in_ready, 1);
        step();
        in_valid = 1'b0;
        drain();
        check("bp_stat_delta", statistic - base, 3);

        // Saturation after restore.
        stat_ld = 1'b1; stat_din = 32'hFFFF_FFFE;
        step();
        stat_ld = 1'b0;
        repeat (3) send($urandom, $urandom, 2'($urandom_range(0, 3)));
        drain();
        check("stat_saturated", statistic, 32'hFFFF_FFFF);

        // Load coincident with a handshake wins.
        out_ready = 1'b0;
        send(32'd1, 32'd1, 2'b00);
        repeat (2) step();
        out_ready = 1'b1; stat_ld = 1'b1; stat_din = 32'h10;
        step();
        stat_ld = 1'b0;
        check("stat_ld_wins", statistic, 32'h10);
        drain();

        // Flush with two operations in flight.
        out_ready = 1'b0;
        base = statistic;
        send(32'd8, 32'd9, 2'b00);
        send(32'd8, 32'd9, 2'b10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_valid", out_valid, 0);
        check("flush_stat", statistic, base);
        out_ready = 1'b1;
        send(32'd100, 32'd1, 2'b01);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom_range(0, 3));
            ain       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 70000));
            bin       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 70000));
            flush     = ($urandom_range(0, 39) == 0);
            stat_ld   = ($urandom_range(0, 49) == 0);
            stat_din  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0; flush = 1'b0; stat_ld = 1'b0;
        drain();

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        send(32'd2, 32'd3, 2'b10);
        send(32'd4, 32'd5, 2'b00);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_stat", statistic, 0);
        check("arst_result", {ovf, result}, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        send(32'd6, 32'd7, 2'b11);
        drain();
        check("final_stat", statistic, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
